// File: rtl/nes_oam_dma.sv
// Sprite DMA engine: a CPU write to $4014 halts the CPU and copies
// one 256-byte page into PPU OAM through $2004.
module nes_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        CPU_CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic        CPU_RW_n,
  input  logic [7:0]  DATA_BUS,
  output logic        CPU_ENABLE,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic [7:0]  DMA_DATA_OUT,
  output logic        DMA_RW_n,
  output logic        DMA_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic       parity_q;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] latch_q, latch_d;
  logic       trigger;

  assign trigger = !CPU_RW_n && (CPU_ADDR == DMA_REG_ADDR);

  always_ff @(posedge CPU_CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      latch_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      page_q   <= page_d;
      index_q  <= index_d;
      latch_q  <= latch_d;
    end
  end

  // Outputs decode only the state register; CPU inputs steer next state.
  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    index_d      = index_q;
    latch_d      = latch_q;
    CPU_ENABLE   = 1'b0;
    DMA_ACTIVE   = 1'b0;
    DMA_BUSY     = 1'b1;
    DMA_ADDR     = 16'h0000;
    DMA_DATA_OUT = 8'h00;
    DMA_RW_n     = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        CPU_ENABLE = 1'b1;
        DMA_BUSY   = 1'b0;
        if (trigger) begin
          state_d = S_HALT;
          page_d  = CPU_DATA_OUT;
          index_d = 8'h00;
        end
      end
      // Reads must land on a "get" cycle, so an odd start
      // needs one extra alignment cycle.
      S_HALT: begin
        state_d = parity_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        DMA_ACTIVE = 1'b1;
        DMA_ADDR   = {page_q, index_q};
        latch_d    = DATA_BUS;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        DMA_ACTIVE   = 1'b1;
        DMA_ADDR     = OAM_DATA_ADDR;
        DMA_DATA_OUT = latch_q;
        DMA_RW_n     = 1'b0;
        if (index_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          index_d = index_q + 8'h01;
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Scoreboard bench for nes_oam_dma: expected bus transfers are queued
// by the stimulus and checked by a monitor on every active cycle.
module tb_nes_oam_dma;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_rw_n = 1'b1;
  logic [7:0]  data_bus;
  logic        cpu_enable;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_rw_n;
  logic        dma_busy;

  xfer_t       sb[$];
  int          checks = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  int          oam_wr = 0;
  logic [7:0]  first_wr;
  logic [7:0]  last_wr;
  logic [15:0] last_rd;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h59;
  endfunction

  assign data_bus = mem_byte(dma_addr);

  nes_oam_dma dut (
    .CPU_CLK     (clk),
    .RESET       (rst),
    .CPU_ADDR    (cpu_addr),
    .CPU_DATA_OUT(cpu_dout),
    .CPU_RW_n    (cpu_rw_n),
    .DATA_BUS    (data_bus),
    .CPU_ENABLE  (cpu_enable),
    .DMA_ACTIVE  (dma_active),
    .DMA_ADDR    (dma_addr),
    .DMA_DATA_OUT(dma_dout),
    .DMA_RW_n    (dma_rw_n),
    .DMA_BUSY    (dma_busy)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    xfer_t e;
    if (mon_en && dma_active) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got addr %h rw %b expected none",
                 dma_addr, dma_rw_n);
      end else begin
        e = sb.pop_front();
        if (dma_addr !== e.addr || dma_rw_n !== e.rw_n ||
            (!e.rw_n && dma_dout !== e.data)) begin
          fails++;
          $display("FAIL sb_xfer: got %h/%b/%h expected %h/%b/%h",
                   dma_addr, dma_rw_n, dma_dout,
                   e.addr, e.rw_n, e.data);
        end
        if (dma_rw_n) last_rd = dma_addr;
        else begin
          if (oam_wr == 0) first_wr = dma_dout;
          last_wr = dma_dout;
          oam_wr++;
        end
      end
    end else if (mon_en) begin
      checks++;
      if (dma_addr !== 16'h0000 || dma_dout !== 8'h00 ||
          dma_rw_n !== 1'b1) begin
        fails++;
        $display("FAIL idle_bus: got %h/%h/%b expected 0000/00/1",
                 dma_addr, dma_dout, dma_rw_n);
      end
    end
  end

  task automatic push_page(input logic [7:0] page, input int n);
    xfer_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = {page, 8'(i)};
      e.data = 8'h00;
      e.rw_n = 1'b1;
      sb.push_back(e);
      e.addr = 16'h2004;
      e.data = mem_byte({page, 8'(i)});
      e.rw_n = 1'b0;
      sb.push_back(e);
    end
  endtask

  // Leaves time at #1 after the final reset edge, parity = 0.
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_enable", 32'(cpu_enable), 32'd1);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_dma_busy", 32'(dma_busy), 32'd0);
    check("rst_bus", {dma_addr, dma_dout, 7'd0, dma_rw_n},
          {16'h0000, 8'h00, 8'h01});
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dout = d;
    cpu_rw_n = 1'b0;
    @(posedge clk);
    #1;
    cpu_addr = 16'h0000;
    cpu_rw_n = 1'b1;
  endtask

  task automatic run(input logic [7:0] page, input int dly,
                     input int exp_len);
    int len;
    push_page(page, 256);
    oam_wr = 0;
    repeat (dly) begin
      @(posedge clk);
      #1;
    end
    cpu_write(16'h4014, page);
    len = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (cpu_enable) break;
      len++;
    end
    check("halt_len", 32'(len), 32'(exp_len));
    check("oam_writes", 32'(oam_wr), 32'd256);
    check("sb_drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    run(8'h02, 0, 513);

    do_reset();
    run(8'h02, 1, 514);

    do_reset();
    run(8'h03, 0, 513);
    check("p3_first", 32'(first_wr), 32'h5A);
    check("p3_last", 32'(last_wr), 32'hA5);

    do_reset();
    run(8'hFF, 1, 514);
    check("pff_last_rd", 32'(last_rd), 32'hFFFF);

    // abort in the WRITE of index 0x40
    do_reset();
    push_page(8'h07, 8'h41);
    cpu_write(16'h4014, 8'h07);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dma_active) break;
    end
    check("abort_started", 32'(dma_active), 32'd1);
    repeat (129) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_cpu_enable", 32'(cpu_enable), 32'd1);
    check("abort_dma_active", 32'(dma_active), 32'd0);
    check("abort_dma_busy", 32'(dma_busy), 32'd0);
    repeat (19) @(negedge clk);
    check("abort_drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    run(8'h05, 0, 513);

    // non-triggering accesses
    do_reset();
    cpu_addr = 16'h4014;
    cpu_dout = 8'h02;
    cpu_rw_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rd4014_busy", 32'(dma_busy), 32'd0);
    cpu_write(16'h4015, 8'h02);
    repeat (2) @(posedge clk);
    #1;
    check("wr4015_busy", 32'(dma_busy), 32'd0);
    check("wr4015_enable", 32'(cpu_enable), 32'd1);

    // reset wins over a simultaneous trigger
    rst = 1'b1;
    cpu_addr = 16'h4014;
    cpu_dout = 8'h02;
    cpu_rw_n = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_addr = 16'h0000;
    cpu_rw_n = 1'b1;
    @(negedge clk);
    check("rst_prio_busy", 32'(dma_busy), 32'd0);
    repeat (4) @(negedge clk);
    check("rst_prio_enable", 32'(cpu_enable), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
